// File: rtl/mmix_defs.sv
// Shared memory-interface definitions: access sizes, arbiter states, request payloads.
package mmix_defs;

   localparam int unsigned ADDR_W = 64;
   localparam int unsigned DATA_W = 64;
   localparam int unsigned BE_W   = 8;

   typedef enum logic [1:0] {
      SIZE_BYTE  = 2'd0,
      SIZE_WYDE  = 2'd1,
      SIZE_TETRA = 2'd2,
      SIZE_OCTA  = 2'd3
   } mem_size_e;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ISSUE  = 2'd1,
      S_RDWAIT = 2'd2,
      S_RESP   = 2'd3
   } arb_state_e;

   typedef enum logic {
      PORT_DATA  = 1'b0,
      PORT_FETCH = 1'b1
   } port_e;

   // Request as presented by the winning port at grant time
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      mem_size_e         size;
      logic [DATA_W-1:0] wdata;
      logic              write;
      port_e             port;
   } mem_req_t;

   // Fields still needed after the bus command registers are loaded
   typedef struct packed {
      logic [2:0] addr_lo;
      mem_size_e  size;
      logic       write;
      port_e      port;
   } xfer_t;

endpackage

// File: rtl/mem_lane_steer.sv
// Big-endian lane steering: byte offset k lives in lane 7-k. EXTRACT selects
// read extraction (right-justify, zero-extend) instead of write placement.
module mem_lane_steer
   import mmix_defs::*;
#(
   parameter bit EXTRACT = 1'b0
) (
   input  logic [2:0]        addr_lo,
   input  mem_size_e         size,
   input  logic [DATA_W-1:0] data_in,
   output logic [BE_W-1:0]   byteenable_c,
   output logic [DATA_W-1:0] data_c
);

   logic [2:0]        offset;
   logic [3:0]        nbytes;
   logic [2:0]        lane_lo;
   logic [BE_W-1:0]   size_mask;
   logic [BE_W-1:0]   lane_mask;
   logic [DATA_W-1:0] data_mask;

   // Size-aligned offset: drop the low address bits covered by the access
   always_comb begin
      offset = addr_lo;
      case (size)
         SIZE_BYTE:  offset = addr_lo;
         SIZE_WYDE:  offset = {addr_lo[2:1], 1'b0};
         SIZE_TETRA: offset = {addr_lo[2], 2'b00};
         default:    offset = 3'b000;
      endcase
   end

   assign nbytes       = 4'd1 << size;
   assign lane_lo      = 3'(4'd8 - 4'(offset) - nbytes);
   assign size_mask    = 8'((16'd1 << nbytes) - 16'd1);
   assign byteenable_c = size_mask << lane_lo;

   always_comb begin
      data_mask = '0;
      for (int j = 0; j < int'(BE_W); j++) begin
         data_mask[8*j +: 8] = {8{lane_mask[j]}};
      end
   end

   generate
      if (EXTRACT) begin : g_extract
         assign lane_mask = size_mask;
         assign data_c    = (data_in >> {lane_lo, 3'b000}) & data_mask;
      end else begin : g_place
         assign lane_mask = byteenable_c;
         assign data_c    = (data_in << {lane_lo, 3'b000}) & data_mask;
      end
   endgenerate

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one 64-bit bus between the data port and the
// instruction-fetch port; one transaction in flight at a time.
module mem_port_arbiter
   import mmix_defs::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] d_address,
   input  logic [1:0]        d_datasize,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [DATA_W-1:0] d_writedata,
   output logic [DATA_W-1:0] d_readdata,
   output logic              d_done,
   input  logic [ADDR_W-1:0] i_address,
   input  logic              i_read,
   output logic [DATA_W-1:0] i_readdata,
   output logic              i_done,
   output logic [ADDR_W-1:0] bus_address,
   output logic [BE_W-1:0]   bus_byteenable,
   output logic              bus_read,
   output logic              bus_write,
   output logic [DATA_W-1:0] bus_writedata,
   input  logic [DATA_W-1:0] bus_readdata,
   input  logic              bus_waitrequest,
   input  logic              bus_readdatavalid
);

   arb_state_e        state, state_nxt;
   port_e             last_grant, last_grant_nxt;
   xfer_t             req_q, req_nxt;
   mem_req_t          cand;
   logic              d_req, grant_fetch;
   logic [2:0]        steer_addr_lo;
   mem_size_e         steer_size;
   logic [BE_W-1:0]   wr_be, rd_be, bus_byteenable_nxt;
   logic [DATA_W-1:0] wr_data, rd_data, bus_writedata_nxt;
   logic [ADDR_W-1:0] bus_address_nxt;
   logic              bus_read_nxt, bus_write_nxt, d_done_nxt, i_done_nxt;
   logic [DATA_W-1:0] d_readdata_nxt, i_readdata_nxt;

   assign d_req       = d_read | d_write;
   assign grant_fetch = i_read && (!d_req || last_grant == PORT_DATA);

   // Candidate request from whichever port would win this cycle
   always_comb begin
      cand = '0;
      if (grant_fetch) begin
         cand.addr  = i_address;
         cand.size  = SIZE_OCTA;
         cand.port  = PORT_FETCH;
      end else begin
         cand.addr  = d_address;
         cand.size  = mem_size_e'(d_datasize);
         cand.wdata = d_writedata;
         cand.write = d_write;
         cand.port  = PORT_DATA;
      end
   end

   // Steer the candidate at grant time, the latched request afterwards
   always_comb begin
      steer_addr_lo = req_q.addr_lo;
      steer_size    = req_q.size;
      if (state == S_IDLE) begin
         steer_addr_lo = cand.addr[2:0];
         steer_size    = cand.size;
      end
   end

   mem_lane_steer #(.EXTRACT(1'b0)) u_steer_wr (
      .addr_lo      (steer_addr_lo),
      .size         (steer_size),
      .data_in      (cand.wdata),
      .byteenable_c (wr_be),
      .data_c       (wr_data)
   );

   mem_lane_steer #(.EXTRACT(1'b1)) u_steer_rd (
      .addr_lo      (steer_addr_lo),
      .size         (steer_size),
      .data_in      (bus_readdata),
      .byteenable_c (rd_be),
      .data_c       (rd_data)
   );

   always_comb begin
      state_nxt          = state;
      last_grant_nxt     = last_grant;
      req_nxt            = req_q;
      bus_address_nxt    = bus_address;
      bus_byteenable_nxt = bus_byteenable;
      bus_writedata_nxt  = bus_writedata;
      bus_read_nxt       = bus_read;
      bus_write_nxt      = bus_write;
      d_done_nxt         = 1'b0;
      i_done_nxt         = 1'b0;
      d_readdata_nxt     = d_readdata;
      i_readdata_nxt     = i_readdata;
      case (state)
         S_IDLE: begin
            if (d_req || i_read) begin
               state_nxt          = S_ISSUE;
               last_grant_nxt     = cand.port;
               req_nxt.addr_lo    = cand.addr[2:0];
               req_nxt.size       = cand.size;
               req_nxt.write      = cand.write;
               req_nxt.port       = cand.port;
               bus_address_nxt    = {cand.addr[ADDR_W-1:3], 3'b000};
               bus_byteenable_nxt = cand.write ? wr_be : rd_be;
               bus_writedata_nxt  = cand.write ? wr_data : '0;
               bus_read_nxt       = !cand.write;
               bus_write_nxt      = cand.write;
            end
         end
         S_ISSUE: begin
            if (!bus_waitrequest) begin
               bus_read_nxt  = 1'b0;
               bus_write_nxt = 1'b0;
               if (req_q.write) begin
                  state_nxt  = S_RESP;
                  d_done_nxt = 1'b1;
               end else begin
                  state_nxt  = S_RDWAIT;
               end
            end
         end
         S_RDWAIT: begin
            if (bus_readdatavalid) begin
               state_nxt = S_RESP;
               if (req_q.port == PORT_FETCH) begin
                  i_readdata_nxt = rd_data;
                  i_done_nxt     = 1'b1;
               end else begin
                  d_readdata_nxt = rd_data;
                  d_done_nxt     = 1'b1;
               end
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= S_IDLE;
         last_grant     <= PORT_FETCH;
         req_q          <= '0;
         bus_address    <= '0;
         bus_byteenable <= '0;
         bus_writedata  <= '0;
         bus_read       <= 1'b0;
         bus_write      <= 1'b0;
         d_done         <= 1'b0;
         i_done         <= 1'b0;
         d_readdata     <= '0;
         i_readdata     <= '0;
      end else begin
         state          <= state_nxt;
         last_grant     <= last_grant_nxt;
         req_q          <= req_nxt;
         bus_address    <= bus_address_nxt;
         bus_byteenable <= bus_byteenable_nxt;
         bus_writedata  <= bus_writedata_nxt;
         bus_read       <= bus_read_nxt;
         bus_write      <= bus_write_nxt;
         d_done         <= d_done_nxt;
         i_done         <= i_done_nxt;
         d_readdata     <= d_readdata_nxt;
         i_readdata     <= i_readdata_nxt;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized
// single-port traffic against a byte-level big-endian reference model.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [63:0] d_address, d_writedata, d_readdata;
   logic [1:0]  d_datasize;
   logic        d_read, d_write, d_done;
   logic [63:0] i_address, i_readdata;
   logic        i_read, i_done;
   logic [63:0] bus_address, bus_writedata, bus_readdata;
   logic [7:0]  bus_byteenable;
   logic        bus_read, bus_write, bus_waitrequest, bus_readdatavalid;

   int          checks = 0;
   int          errors = 0;
   logic [63:0] exp_d_rdata, exp_i_rdata;

   mem_port_arbiter dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .d_address         (d_address),
      .d_datasize        (d_datasize),
      .d_read            (d_read),
      .d_write           (d_write),
      .d_writedata       (d_writedata),
      .d_readdata        (d_readdata),
      .d_done            (d_done),
      .i_address         (i_address),
      .i_read            (i_read),
      .i_readdata        (i_readdata),
      .i_done            (i_done),
      .bus_address       (bus_address),
      .bus_byteenable    (bus_byteenable),
      .bus_read          (bus_read),
      .bus_write         (bus_write),
      .bus_writedata     (bus_writedata),
      .bus_readdata      (bus_readdata),
      .bus_waitrequest   (bus_waitrequest),
      .bus_readdatavalid (bus_readdatavalid)
   );

   always #5 clk = ~clk;

   // Reference model: an access of n=2^sz bytes covers offsets o..o+n-1, the
   // most significant value byte at the lowest offset, offset k on lane 7-k.
   function automatic logic [7:0] model_be(input logic [2:0] a, input int sz);
      int n;
      int o;
      logic [7:0] be;
      n  = 1 << sz;
      o  = (int'(a) / n) * n;
      be = '0;
      for (int k = 0; k < n; k++) be[7 - (o + k)] = 1'b1;
      return be;
   endfunction

   function automatic logic [63:0] model_wdata(input logic [2:0] a, input int sz, input logic [63:0] v);
      int n;
      int o;
      logic [63:0] r;
      n = 1 << sz;
      o = (int'(a) / n) * n;
      r = '0;
      for (int k = 0; k < n; k++) r[8*(7 - (o + k)) +: 8] = v[8*(n - 1 - k) +: 8];
      return r;
   endfunction

   function automatic logic [63:0] model_rdata(input logic [2:0] a, input int sz, input logic [63:0] bus);
      int n;
      int o;
      logic [63:0] r;
      n = 1 << sz;
      o = (int'(a) / n) * n;
      r = '0;
      for (int k = 0; k < n; k++) r[8*(n - 1 - k) +: 8] = bus[8*(7 - (o + k)) +: 8];
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drop_requests();
      d_read  = 1'b0;
      d_write = 1'b0;
      i_read  = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      d_address = '0; d_datasize = '0; d_writedata = '0; i_address = '0;
      d_read = 1'b1; d_write = 1'b0; i_read = 1'b0;
      bus_readdata = '0; bus_waitrequest = 1'b0; bus_readdatavalid = 1'b0;
      exp_d_rdata = '0; exp_i_rdata = '0;
      repeat (3) tick();
      checks++;
      if ({bus_read, bus_write, d_done, i_done} !== 4'b0000 || bus_address !== 64'h0 || bus_byteenable !== 8'h00 ||
          bus_writedata !== 64'h0 || d_readdata !== 64'h0 || i_readdata !== 64'h0) begin
         errors++;
         $display("FAIL reset_outputs: got rd=%b wr=%b dd=%b id=%b addr=%h be=%h wd=%h drd=%h ird=%h expected all zero",
                  bus_read, bus_write, d_done, i_done, bus_address, bus_byteenable, bus_writedata, d_readdata, i_readdata);
      end
      d_read = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      tick();
      checks++;
      if (bus_read !== 1'b0 || bus_write !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: got rd=%b wr=%b expected 0 0", bus_read, bus_write);
      end
   endtask

   task automatic test_write_stb();
      d_address = 64'h0000_0000_0000_1005; d_datasize = 2'd0; d_writedata = 64'h1AB; d_write = 1'b1;
      tick();
      checks++;
      if (bus_write !== 1'b1 || bus_read !== 1'b0 || bus_byteenable !== 8'h04 || bus_address !== 64'h1000) begin
         errors++;
         $display("FAIL stb_issue: got wr=%b rd=%b be=%h addr=%h expected wr=1 rd=0 be=04 addr=1000",
                  bus_write, bus_read, bus_byteenable, bus_address);
      end
      checks++;
      if (bus_writedata !== model_wdata(3'd5, 0, 64'h1AB) || bus_writedata[23:16] !== 8'hAB) begin
         errors++;
         $display("FAIL stb_wdata: got %h expected %h", bus_writedata, model_wdata(3'd5, 0, 64'h1AB));
      end
      tick();
      checks++;
      if (d_done !== 1'b1 || i_done !== 1'b0 || bus_write !== 1'b0) begin
         errors++;
         $display("FAIL stb_done_cycle2: got dd=%b id=%b wr=%b expected 1 0 0", d_done, i_done, bus_write);
      end
      d_write = 1'b0;
      tick();
      checks++;
      if (d_done !== 1'b0) begin
         errors++;
         $display("FAIL stb_done_pulse: got %b expected 0", d_done);
      end
   endtask

   task automatic test_read_ldw();
      d_address = 64'h0000_0000_0000_2003; d_datasize = 2'd1; d_read = 1'b1;
      tick();
      checks++;
      if (bus_read !== 1'b1 || bus_byteenable !== 8'h30 || bus_byteenable !== model_be(3'd3, 1) || bus_address !== 64'h2000) begin
         errors++;
         $display("FAIL ldw_issue: got rd=%b be=%h addr=%h expected rd=1 be=30 addr=2000", bus_read, bus_byteenable, bus_address);
      end
      tick();
      for (int c = 0; c < 2; c++) begin
         checks++;
         if (d_done !== 1'b0 || bus_read !== 1'b0) begin
            errors++;
            $display("FAIL ldw_wait[%0d]: got dd=%b rd=%b expected 0 0", c, d_done, bus_read);
         end
         tick();
      end
      bus_readdata = 64'h0011_2233_4455_6677; bus_readdatavalid = 1'b1;
      tick();
      bus_readdatavalid = 1'b0;
      exp_d_rdata = 64'h2233;
      checks++;
      if (d_done !== 1'b1 || d_readdata !== 64'h2233 || d_readdata !== model_rdata(3'd3, 1, 64'h0011_2233_4455_6677)) begin
         errors++;
         $display("FAIL ldw_done: got dd=%b data=%h expected dd=1 data=2233", d_done, d_readdata);
      end
      d_read = 1'b0;
      tick();
      checks++;
      if (d_done !== 1'b0 || d_readdata !== exp_d_rdata) begin
         errors++;
         $display("FAIL ldw_hold: got dd=%b data=%h expected dd=0 data=%h", d_done, d_readdata, exp_d_rdata);
      end
   endtask

   task automatic test_random();
      logic        fetch, wr;
      logic [63:0] addr, wd, rdat, exp_addr, exp_wd;
      logic [7:0]  exp_be;
      int          sz, waits, lat;
      for (int t = 0; t < 40; t++) begin
         fetch    = 1'($urandom_range(0, 1));
         wr       = !fetch && ($urandom_range(0, 1) == 1);
         addr     = {$urandom, $urandom};
         sz       = fetch ? 3 : int'($urandom_range(0, 3));
         wd       = {$urandom, $urandom};
         rdat     = {$urandom, $urandom};
         waits    = int'($urandom_range(0, 3));
         lat      = int'($urandom_range(0, 3));
         exp_addr = {addr[63:3], 3'b000};
         exp_be   = model_be(addr[2:0], sz);
         exp_wd   = model_wdata(addr[2:0], sz, wd);
         if (fetch) begin
            i_address = addr; i_read = 1'b1;
         end else begin
            d_address = addr; d_datasize = 2'(sz); d_writedata = wd;
            d_write = wr; d_read = !wr || ($urandom_range(0, 1) == 1);
         end
         tick();
         checks++;
         if ({bus_read, bus_write} !== {!wr, wr} || bus_address !== exp_addr || bus_byteenable !== exp_be) begin
            errors++;
            $display("FAIL rand_issue[%0d]: got rd=%b wr=%b addr=%h be=%h expected rd=%b wr=%b addr=%h be=%h",
                     t, bus_read, bus_write, bus_address, bus_byteenable, !wr, wr, exp_addr, exp_be);
         end
         if (wr) begin
            checks++;
            if (bus_writedata !== exp_wd) begin
               errors++;
               $display("FAIL rand_wdata[%0d]: got %h expected %h", t, bus_writedata, exp_wd);
            end
         end
         d_address = {$urandom, $urandom}; d_datasize = 2'($urandom_range(0, 3));
         d_writedata = {$urandom, $urandom}; i_address = {$urandom, $urandom};
         bus_waitrequest = (waits != 0);
         for (int w = 0; w < waits; w++) begin
            tick();
            checks++;
            if ({bus_read, bus_write} !== {!wr, wr} || bus_address !== exp_addr || bus_byteenable !== exp_be ||
                (wr && bus_writedata !== exp_wd)) begin
               errors++;
               $display("FAIL rand_hold[%0d]: got rd=%b wr=%b addr=%h be=%h expected rd=%b wr=%b addr=%h be=%h",
                        t, bus_read, bus_write, bus_address, bus_byteenable, !wr, wr, exp_addr, exp_be);
            end
            if (w == waits - 1) bus_waitrequest = 1'b0;
         end
         if ($urandom_range(0, 1) == 1) drop_requests();
         tick();
         if (!wr) begin
            checks++;
            if (bus_read !== 1'b0 || d_done !== 1'b0 || i_done !== 1'b0) begin
               errors++;
               $display("FAIL rand_rdwait[%0d]: got rd=%b dd=%b id=%b expected 0 0 0", t, bus_read, d_done, i_done);
            end
            for (int l = 0; l < lat; l++) begin
               tick();
               checks++;
               if (d_done !== 1'b0 || i_done !== 1'b0) begin
                  errors++;
                  $display("FAIL rand_early_done[%0d]: got dd=%b id=%b expected 0 0", t, d_done, i_done);
               end
            end
            bus_readdata = rdat; bus_readdatavalid = 1'b1;
            tick();
            bus_readdatavalid = 1'b0;
            if (fetch) exp_i_rdata = model_rdata(addr[2:0], sz, rdat);
            else       exp_d_rdata = model_rdata(addr[2:0], sz, rdat);
         end
         checks++;
         if ({d_done, i_done} !== {!fetch, fetch} || bus_read !== 1'b0 || bus_write !== 1'b0) begin
            errors++;
            $display("FAIL rand_done[%0d]: got dd=%b id=%b rd=%b wr=%b expected dd=%b id=%b rd=0 wr=0",
                     t, d_done, i_done, bus_read, bus_write, !fetch, fetch);
         end
         checks++;
         if (d_readdata !== exp_d_rdata || i_readdata !== exp_i_rdata) begin
            errors++;
            $display("FAIL rand_rdata[%0d]: got d=%h i=%h expected d=%h i=%h", t, d_readdata, i_readdata, exp_d_rdata, exp_i_rdata);
         end
         drop_requests();
         tick();
         checks++;
         if (d_done !== 1'b0 || i_done !== 1'b0 || bus_read !== 1'b0 || bus_write !== 1'b0) begin
            errors++;
            $display("FAIL rand_idle[%0d]: got dd=%b id=%b rd=%b wr=%b expected 0 0 0 0", t, d_done, i_done, bus_read, bus_write);
         end
      end
   endtask

   task automatic test_waitrequest();
      logic [63:0] addr, wd;
      addr = {$urandom, $urandom};
      wd   = {$urandom, $urandom};
      d_address = addr; d_datasize = 2'd3; d_writedata = wd;
      d_write = 1'b1; d_read = 1'b1;
      tick();
      bus_waitrequest = 1'b1;
      for (int c = 0; c < 5; c++) begin
         checks++;
         if (bus_write !== 1'b1 || bus_read !== 1'b0 || bus_writedata !== wd || bus_byteenable !== 8'hFF ||
             bus_address !== {addr[63:3], 3'b000} || d_done !== 1'b0) begin
            errors++;
            $display("FAIL sto_stable[%0d]: got wr=%b rd=%b wd=%h be=%h addr=%h dd=%b expected wr=1 rd=0 wd=%h be=ff addr=%h dd=0",
                     c, bus_write, bus_read, bus_writedata, bus_byteenable, bus_address, d_done, wd, {addr[63:3], 3'b000});
         end
         d_address = {$urandom, $urandom}; d_writedata = {$urandom, $urandom};
         d_datasize = 2'($urandom_range(0, 3));
         if (c == 1) drop_requests();
         if (c == 4) bus_waitrequest = 1'b0;
         tick();
      end
      checks++;
      if (d_done !== 1'b1 || bus_write !== 1'b0) begin
         errors++;
         $display("FAIL sto_done: got dd=%b wr=%b expected 1 0", d_done, bus_write);
      end
      for (int c = 0; c < 2; c++) begin
         tick();
         checks++;
         if (d_done !== 1'b0 || bus_write !== 1'b0) begin
            errors++;
            $display("FAIL sto_single_pulse[%0d]: got dd=%b wr=%b expected 0 0", c, d_done, bus_write);
         end
      end
   endtask

   task automatic test_arbitration();
      logic [63:0] da, ia, rdat;
      logic        exp_fetch;
      da = {$urandom, $urandom};
      ia = {$urandom, $urandom};
      reset_n = 1'b0;
      tick();
      exp_d_rdata = '0; exp_i_rdata = '0;
      d_address = da; d_datasize = 2'd2; i_address = ia;
      d_read = 1'b1; i_read = 1'b1;
      @(negedge clk);
      reset_n = 1'b1;
      for (int g = 0; g < 3; g++) begin
         exp_fetch = (g == 1);
         tick();
         checks++;
         if (bus_read !== 1'b1 || bus_address !== (exp_fetch ? {ia[63:3], 3'b000} : {da[63:3], 3'b000}) ||
             bus_byteenable !== (exp_fetch ? model_be(ia[2:0], 3) : model_be(da[2:0], 2))) begin
            errors++;
            $display("FAIL arb_grant[%0d]: got rd=%b addr=%h be=%h expected port %s", g, bus_read, bus_address, bus_byteenable,
                     exp_fetch ? "fetch" : "data");
         end
         tick();
         rdat = {$urandom, $urandom};
         bus_readdata = rdat; bus_readdatavalid = 1'b1;
         tick();
         bus_readdatavalid = 1'b0;
         if (exp_fetch) exp_i_rdata = model_rdata(ia[2:0], 3, rdat);
         else           exp_d_rdata = model_rdata(da[2:0], 2, rdat);
         checks++;
         if ({d_done, i_done} !== {!exp_fetch, exp_fetch} || d_readdata !== exp_d_rdata || i_readdata !== exp_i_rdata) begin
            errors++;
            $display("FAIL arb_done[%0d]: got dd=%b id=%b d=%h i=%h expected dd=%b id=%b d=%h i=%h", g, d_done, i_done,
                     d_readdata, i_readdata, !exp_fetch, exp_fetch, exp_d_rdata, exp_i_rdata);
         end
         if (g == 2) drop_requests();
         tick();
         checks++;
         if (bus_read !== 1'b0 || d_done !== 1'b0 || i_done !== 1'b0) begin
            errors++;
            $display("FAIL arb_idle_gap[%0d]: got rd=%b dd=%b id=%b expected 0 0 0", g, bus_read, d_done, i_done);
         end
      end
   endtask

   task automatic test_reset_mid();
      d_address = {$urandom, $urandom}; d_datasize = 2'($urandom_range(0, 3)); d_read = 1'b1;
      tick();
      tick();
      checks++;
      if (bus_read !== 1'b0 || d_done !== 1'b0 || bus_address === 64'h0) begin
         errors++;
         $display("FAIL rst_mid_rdwait: got rd=%b dd=%b addr=%h expected rd=0 dd=0 addr nonzero", bus_read, d_done, bus_address);
      end
      #2 reset_n = 1'b0;
      #1;
      d_read = 1'b0;
      exp_d_rdata = '0; exp_i_rdata = '0;
      checks++;
      if ({bus_read, bus_write, d_done, i_done} !== 4'b0000 || bus_address !== 64'h0 || bus_byteenable !== 8'h00 ||
          bus_writedata !== 64'h0 || d_readdata !== 64'h0 || i_readdata !== 64'h0) begin
         errors++;
         $display("FAIL rst_mid_async: got rd=%b wr=%b dd=%b id=%b addr=%h be=%h wd=%h drd=%h ird=%h expected all zero",
                  bus_read, bus_write, d_done, i_done, bus_address, bus_byteenable, bus_writedata, d_readdata, i_readdata);
      end
      @(negedge clk);
      reset_n = 1'b1;
      tick();
      bus_readdata = {$urandom, $urandom}; bus_readdatavalid = 1'b1;
      tick();
      bus_readdatavalid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         checks++;
         if (d_done !== 1'b0 || i_done !== 1'b0 || d_readdata !== 64'h0 || bus_read !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_late_rdv[%0d]: got dd=%b id=%b drd=%h rd=%b expected 0 0 0 0", c, d_done, i_done, d_readdata, bus_read);
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_write_stb();
      test_read_ldw();
      test_random();
      test_waitrequest();
      test_arbitration();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
